// File: rtl/noc_pkg.sv
// Shared NoC definitions: array/VC geometry, flit layout and the NI transmit FSM states.
// Head flits carry routing and source fields; body/tail flits carry a payload word.
package noc_pkg;

  localparam int ARRAY_W = 2;
  localparam int VCHW    = 1;
  localparam int DATA_W  = 16;
  localparam int FLIT_W  = DATA_W + 2;

  localparam int DSTX_MSB = DATA_W - 1;
  localparam int DSTX_LSB = DSTX_MSB - ARRAY_W + 1;
  localparam int DSTY_MSB = DSTX_LSB - 1;
  localparam int DSTY_LSB = DSTY_MSB - ARRAY_W + 1;
  localparam int SRCX_MSB = DSTY_LSB - 1;
  localparam int SRCX_LSB = SRCX_MSB - ARRAY_W + 1;
  localparam int SRCY_MSB = SRCX_LSB - 1;
  localparam int SRCY_LSB = SRCY_MSB - ARRAY_W + 1;
  localparam int VCH_MSB  = SRCY_LSB - 1;
  localparam int VCH_LSB  = VCH_MSB - VCHW + 1;

  typedef enum logic [1:0] {
    FLIT_HEAD     = 2'b00,
    FLIT_BODY     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAD = 2'b01,
    BODY = 2'b10
  } ni_state_e;

  function automatic logic [FLIT_W-1:0] make_head(
    input flit_type_e         ftype,
    input logic [ARRAY_W-1:0] dstx,
    input logic [ARRAY_W-1:0] dsty,
    input logic [ARRAY_W-1:0] srcx,
    input logic [ARRAY_W-1:0] srcy,
    input logic [VCHW-1:0]    vch
  );
    logic [FLIT_W-1:0] f;
    f                     = '0;
    f[FLIT_W-1:FLIT_W-2]  = ftype;
    f[DSTX_MSB:DSTX_LSB]  = dstx;
    f[DSTY_MSB:DSTY_LSB]  = dsty;
    f[SRCX_MSB:SRCX_LSB]  = srcx;
    f[SRCY_MSB:SRCY_LSB]  = srcy;
    f[VCH_MSB:VCH_LSB]    = vch;
    return f;
  endfunction

  function automatic logic [FLIT_W-1:0] make_body(
    input flit_type_e        ftype,
    input logic [DATA_W-1:0] data
  );
    return {ftype, data};
  endfunction

endpackage

// File: rtl/noc_ni_tx_if.sv
// Core-side request/payload handshakes plus router-side flit/credit signals of the NI transmitter.
// master = core/router environment, slave = the NI transmitter itself.
interface noc_ni_tx_if
  import noc_pkg::*;
#(
  parameter int NVCH  = 2,
  parameter int LEN_W = 4
) ();

  logic                req_valid_i;
  logic                req_ready_o;
  logic [ARRAY_W-1:0]  req_dstx_i;
  logic [ARRAY_W-1:0]  req_dsty_i;
  logic [VCHW-1:0]     req_vch_i;
  logic [LEN_W-1:0]    req_len_i;
  logic                pld_valid_i;
  logic                pld_ready_o;
  logic [DATA_W-1:0]   pld_data_i;
  logic                flit_valid_o;
  logic [FLIT_W-1:0]   flit_o;
  logic [VCHW-1:0]     flit_vch_o;
  logic [NVCH-1:0]     credit_i;
  logic                busy_o;

  modport master (
    output req_valid_i, req_dstx_i, req_dsty_i, req_vch_i, req_len_i,
    output pld_valid_i, pld_data_i, credit_i,
    input  req_ready_o, pld_ready_o, flit_valid_o, flit_o, flit_vch_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_dstx_i, req_dsty_i, req_vch_i, req_len_i,
    input  pld_valid_i, pld_data_i, credit_i,
    output req_ready_o, pld_ready_o, flit_valid_o, flit_o, flit_vch_o, busy_o
  );

endinterface

// File: rtl/noc_credit_chk.sv
// Simulation checker: flags a credit return arriving while the counter is already full.
module noc_credit_chk #(
  parameter int BUF_DEPTH = 4
) (
  input logic                           clk,
  input logic                           rst,
  input logic                           dec,
  input logic                           inc,
  input logic [$clog2(BUF_DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(inc && !dec && (count == CNT_W'(BUF_DEPTH))))
    else $warning("credit counter overflow: credit returned at BUF_DEPTH");

endmodule

// File: rtl/noc_ni_tx_credit_cnt.sv
// Per-VC credit counter mirroring free router buffer slots; starts full and saturates at BUF_DEPTH.
module noc_credit_cnt #(
  parameter int BUF_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dec,
  input  logic                           inc,
  output logic [$clog2(BUF_DEPTH+1)-1:0] count,
  output logic                           avail
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [CNT_W-1:0] r_count;

  // Credit update; a simultaneous send and credit return cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= CNT_W'(BUF_DEPTH);
    end else if (inc && !dec) begin
      if (r_count != CNT_W'(BUF_DEPTH)) begin
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_count <= r_count;
      end
    end else if (dec && !inc) begin
      r_count <= r_count - CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;
  assign avail = (r_count != CNT_W'(0));

endmodule

// File: rtl/noc_ni_tx.sv
// NI transmitter: turns core send requests into head/body/tail flits for router port 4,
// gated by per-VC credits. One packet at a time, one flit per cycle at most.
module noc_ni_tx
  import noc_pkg::*;
#(
  parameter int NVCH      = 2,
  parameter int BUF_DEPTH = 4,
  parameter int LEN_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ARRAY_W-1:0] xpos_i,
  input  logic [ARRAY_W-1:0] ypos_i,
  noc_ni_tx_if.slave         bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  ni_state_e          r_state;
  ni_state_e          w_state_nxt;
  logic [ARRAY_W-1:0] r_dstx;
  logic [ARRAY_W-1:0] r_dsty;
  logic [VCHW-1:0]    r_vch;
  logic [LEN_W-1:0]   r_rem;
  logic               r_flit_valid;
  logic [FLIT_W-1:0]  r_flit;
  logic [VCHW-1:0]    r_flit_vch;

  logic               w_accept;
  logic               w_send_head;
  logic               w_send_body;
  logic               w_send;
  logic               w_vc_avail;
  logic [VCHW-1:0]    w_vch_req;
  logic [FLIT_W-1:0]  w_flit_nxt;
  logic [NVCH-1:0]    w_dec;
  logic [NVCH-1:0]    w_avail;
  logic [CNT_W-1:0]   w_count [NVCH];

  for (genvar v = 0; v < NVCH; v++) begin : g_vc
    assign w_dec[v] = w_send && (r_vch == VCHW'(v));

    noc_credit_cnt #(.BUF_DEPTH(BUF_DEPTH)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .dec   (w_dec[v]),
      .inc   (bus.credit_i[v]),
      .count (w_count[v]),
      .avail (w_avail[v])
    );

    noc_credit_chk #(.BUF_DEPTH(BUF_DEPTH)) u_chk (
      .clk   (clk),
      .rst   (rst),
      .dec   (w_dec[v]),
      .inc   (bus.credit_i[v]),
      .count (w_count[v])
    );
  end

  assign w_vc_avail = w_avail[r_vch];
  assign w_send     = w_send_head || w_send_body;
  assign w_vch_req  = (int'(bus.req_vch_i) >= NVCH) ? '0 : bus.req_vch_i;

  // Next-state and send decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_send_head = 1'b0;
    w_send_body = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = bus.req_valid_i;
        if (bus.req_valid_i) w_state_nxt = HEAD;
        else                 w_state_nxt = IDLE;
      end
      HEAD: begin
        w_send_head = w_vc_avail;
        if (!w_vc_avail)             w_state_nxt = HEAD;
        else if (r_rem == LEN_W'(0)) w_state_nxt = IDLE;
        else                         w_state_nxt = BODY;
      end
      BODY: begin
        w_send_body = w_vc_avail && bus.pld_valid_i;
        if (w_send_body && (r_rem == LEN_W'(1))) w_state_nxt = IDLE;
        else                                     w_state_nxt = BODY;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Flit contents for whichever send happens this cycle.
  always_comb begin
    if (w_send_head) begin
      w_flit_nxt = make_head((r_rem == LEN_W'(0)) ? FLIT_HEADTAIL : FLIT_HEAD,
                             r_dstx, r_dsty, xpos_i, ypos_i, r_vch);
    end else begin
      w_flit_nxt = make_body((r_rem == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY, bus.pld_data_i);
    end
  end

  // State, packet context and registered flit outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_dstx       <= '0;
      r_dsty       <= '0;
      r_vch        <= '0;
      r_rem        <= '0;
      r_flit_valid <= 1'b0;
      r_flit       <= '0;
      r_flit_vch   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_flit_valid <= w_send;
      if (w_send) begin
        r_flit     <= w_flit_nxt;
        r_flit_vch <= r_vch;
      end
      if (w_accept) begin
        r_dstx <= bus.req_dstx_i;
        r_dsty <= bus.req_dsty_i;
        r_vch  <= w_vch_req;
        // remaining counts flits after the head; a zero length still yields one flit
        r_rem  <= (bus.req_len_i == LEN_W'(0)) ? LEN_W'(0) : bus.req_len_i - LEN_W'(1);
      end else if (w_send_body) begin
        r_rem <= r_rem - LEN_W'(1);
      end
    end
  end

  assign bus.req_ready_o  = (r_state == IDLE);
  assign bus.pld_ready_o  = w_send_body;
  assign bus.flit_valid_o = r_flit_valid;
  assign bus.flit_o       = r_flit;
  assign bus.flit_vch_o   = r_flit_vch;
  assign bus.busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_noc_ni_tx.sv
// Directed bench for noc_ni_tx: drives on the falling edge, samples registered outputs there
// and combinational ready signals 1 time unit after driving.
module tb_noc_ni_tx;
  import noc_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        xpos;
  logic [1:0]        ypos;
  int                total = 0;
  int                bad   = 0;
  int                words;
  logic [15:0]       pld_q [8];
  logic              rdy;

  noc_ni_tx_if #(.NVCH(2), .LEN_W(4)) bus ();

  noc_ni_tx #(.NVCH(2), .BUF_DEPTH(4), .LEN_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .xpos_i (xpos),
    .ypos_i (ypos),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic int cnt(input int v);
    if (v == 0) return int'(dut.g_vc[0].u_cnt.count);
    else        return int'(dut.g_vc[1].u_cnt.count);
  endfunction

  // one clock: payload word advances only when the DUT consumed it at this edge
  task automatic tick();
    #1;
    rdy = bus.pld_valid_i && bus.pld_ready_o;
    @(negedge clk);
    if (rdy) words++;
    bus.pld_data_i = pld_q[words % 8];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_dstx_i  = 2'd0;
    bus.req_dsty_i  = 2'd0;
    bus.req_vch_i   = 1'b0;
    bus.req_len_i   = 4'd0;
    bus.pld_valid_i = 1'b0;
    bus.credit_i    = 2'b00;
    words = 0;
    bus.pld_data_i  = pld_q[0];
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_req(input logic [1:0] dx, input logic [1:0] dy, input logic vc, input logic [3:0] len);
    bus.req_valid_i = 1'b1;
    bus.req_dstx_i  = dx;
    bus.req_dsty_i  = dy;
    bus.req_vch_i   = vc;
    bus.req_len_i   = len;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (bus.flit_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.flit_valid_o); end
    total++; if (bus.flit_o !== 18'h0) begin bad++; $display("FAIL rst_flit got=%h exp=0", bus.flit_o); end
    total++; if (bus.flit_vch_o !== 1'b0) begin bad++; $display("FAIL rst_vch got=%b exp=0", bus.flit_vch_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy_o); end
    total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready_o); end
    total++; if (bus.pld_ready_o !== 1'b0) begin bad++; $display("FAIL rst_pld_ready got=%b exp=0", bus.pld_ready_o); end
    total++; if (cnt(0) != 4 || cnt(1) != 4) begin bad++; $display("FAIL rst_credits got=%0d,%0d exp=4,4", cnt(0), cnt(1)); end
  endtask

  task automatic test_packet();
    pld_q[0] = 16'h00A5; pld_q[1] = 16'h005A;
    do_reset();
    send_req(2'd3, 2'd2, 1'b1, 4'd3);
    bus.pld_valid_i = 1'b1;
    #1;
    total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL pkt_req_ready got=%b exp=1", bus.req_ready_o); end
    tick();
    bus.req_valid_i = 1'b0;
    total++; if (bus.flit_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin bad++; $display("FAIL pkt_cycle1 valid=%b busy=%b exp valid=0 busy=1", bus.flit_valid_o, bus.busy_o); end
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h0E580 || bus.flit_vch_o !== 1'b1) begin bad++; $display("FAIL pkt_head valid=%b flit=%h vch=%b exp 1/0e580/1", bus.flit_valid_o, bus.flit_o, bus.flit_vch_o); end
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h100A5) begin bad++; $display("FAIL pkt_body valid=%b flit=%h exp 1/100a5", bus.flit_valid_o, bus.flit_o); end
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h2005A) begin bad++; $display("FAIL pkt_tail valid=%b flit=%h exp 1/2005a", bus.flit_valid_o, bus.flit_o); end
    total++; if (cnt(1) != 1) begin bad++; $display("FAIL pkt_credit1 got=%0d exp=1", cnt(1)); end
    bus.pld_valid_i = 1'b0;
    tick();
    total++; if (bus.flit_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL pkt_end valid=%b busy=%b exp 0/0", bus.flit_valid_o, bus.busy_o); end
  endtask

  task automatic test_len01();
    pld_q[0] = 16'hDEAD;
    do_reset();
    bus.pld_valid_i = 1'b1;
    send_req(2'd2, 2'd1, 1'b0, 4'd0);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    total++; if (bus.pld_ready_o !== 1'b0) begin bad++; $display("FAIL len0_pld_ready got=%b exp=0", bus.pld_ready_o); end
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h39500) begin bad++; $display("FAIL len0_headtail valid=%b flit=%h exp 1/39500", bus.flit_valid_o, bus.flit_o); end
    total++; if (bus.busy_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL len0_idle busy=%b ready=%b exp 0/1", bus.busy_o, bus.req_ready_o); end
    send_req(2'd0, 2'd3, 1'b1, 4'd1);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    total++; if (bus.pld_ready_o !== 1'b0) begin bad++; $display("FAIL len1_pld_ready got=%b exp=0", bus.pld_ready_o); end
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h33580 || bus.flit_vch_o !== 1'b1) begin bad++; $display("FAIL len1_headtail valid=%b flit=%h vch=%b exp 1/33580/1", bus.flit_valid_o, bus.flit_o, bus.flit_vch_o); end
    total++; if (cnt(0) != 3 || cnt(1) != 3 || words != 0) begin bad++; $display("FAIL len01_counts cnt=%0d,%0d words=%0d exp 3,3,0", cnt(0), cnt(1), words); end
  endtask

  task automatic test_credit_stall();
    for (int i = 0; i < 8; i++) pld_q[i] = 16'h0100 + 16'(i);
    do_reset();
    bus.pld_valid_i = 1'b1;
    send_req(2'd1, 2'd2, 1'b0, 4'd6);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h06500) begin bad++; $display("FAIL cs_head valid=%b flit=%h exp 1/06500", bus.flit_valid_o, bus.flit_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== (18'h10100 + 18'(i))) begin bad++; $display("FAIL cs_body%0d valid=%b flit=%h exp 1/%h", i, bus.flit_valid_o, bus.flit_o, 18'h10100 + 18'(i)); end
    end
    total++; if (cnt(0) != 0) begin bad++; $display("FAIL cs_credit_zero got=%0d exp=0", cnt(0)); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (bus.flit_valid_o !== 1'b0) begin bad++; $display("FAIL cs_stall%0d valid=%b exp=0", i, bus.flit_valid_o); end
    end
    #1;
    total++; if (bus.pld_ready_o !== 1'b0) begin bad++; $display("FAIL cs_stall_pld_ready got=%b exp=0", bus.pld_ready_o); end
    bus.credit_i = 2'b01;
    tick();
    bus.credit_i = 2'b00;
    total++; if (bus.flit_valid_o !== 1'b0) begin bad++; $display("FAIL cs_credit_same_cycle valid=%b exp=0", bus.flit_valid_o); end
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h10103) begin bad++; $display("FAIL cs_resume valid=%b flit=%h exp 1/10103", bus.flit_valid_o, bus.flit_o); end
    tick();
    total++; if (bus.flit_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin bad++; $display("FAIL cs_one_only valid=%b busy=%b exp 0/1", bus.flit_valid_o, bus.busy_o); end
    bus.credit_i = 2'b01;
    tick();
    bus.credit_i = 2'b00;
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h20104) begin bad++; $display("FAIL cs_tail valid=%b flit=%h exp 1/20104", bus.flit_valid_o, bus.flit_o); end
    bus.pld_valid_i = 1'b0;
    tick();
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL cs_done busy=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_payload_gap();
    pld_q[0] = 16'h0011; pld_q[1] = 16'h0022; pld_q[2] = 16'h0033;
    do_reset();
    bus.pld_valid_i = 1'b1;
    send_req(2'd3, 2'd3, 1'b1, 4'd4);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h0F580) begin bad++; $display("FAIL gap_head valid=%b flit=%h exp 1/0f580", bus.flit_valid_o, bus.flit_o); end
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h10011) begin bad++; $display("FAIL gap_body0 valid=%b flit=%h exp 1/10011", bus.flit_valid_o, bus.flit_o); end
    bus.pld_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.flit_valid_o !== 1'b0) begin bad++; $display("FAIL gap_hole%0d valid=%b exp=0", i, bus.flit_valid_o); end
    end
    bus.pld_valid_i = 1'b1;
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h10022) begin bad++; $display("FAIL gap_body1 valid=%b flit=%h exp 1/10022", bus.flit_valid_o, bus.flit_o); end
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h20033) begin bad++; $display("FAIL gap_tail valid=%b flit=%h exp 1/20033", bus.flit_valid_o, bus.flit_o); end
    bus.pld_valid_i = 1'b0;
    tick();
    total++; if (bus.flit_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL gap_end valid=%b busy=%b exp 0/0", bus.flit_valid_o, bus.busy_o); end
  endtask

  task automatic test_credit_edges();
    pld_q[0] = 16'h00BB;
    do_reset();
    bus.pld_valid_i = 1'b1;
    send_req(2'd1, 2'd0, 1'b0, 4'd2);
    tick();
    bus.req_valid_i = 1'b0;
    bus.credit_i = 2'b01;
    tick();
    bus.credit_i = 2'b00;
    total++; if (bus.flit_valid_o !== 1'b1 || cnt(0) != 4) begin bad++; $display("FAIL ce_send_and_credit valid=%b cnt=%0d exp 1/4", bus.flit_valid_o, cnt(0)); end
    tick();
    total++; if (bus.flit_o !== 18'h200BB || cnt(0) != 3) begin bad++; $display("FAIL ce_tail flit=%h cnt=%0d exp 200bb/3", bus.flit_o, cnt(0)); end
    bus.pld_valid_i = 1'b0;
    bus.credit_i = 2'b10;
    tick();
    bus.credit_i = 2'b00;
    total++; if (cnt(1) != 4 || cnt(0) != 3) begin bad++; $display("FAIL ce_saturate cnt=%0d,%0d exp 3,4", cnt(0), cnt(1)); end
  endtask

  task automatic test_reset_mid();
    pld_q[0] = 16'h0C01; pld_q[1] = 16'h0C02; pld_q[2] = 16'h0C03;
    do_reset();
    bus.pld_valid_i = 1'b1;
    send_req(2'd2, 2'd2, 1'b0, 4'd4);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h10C01) begin bad++; $display("FAIL rm_body valid=%b flit=%h exp 1/10c01", bus.flit_valid_o, bus.flit_o); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.flit_valid_o !== 1'b0 || bus.flit_o !== 18'h0 || bus.busy_o !== 1'b0) begin bad++; $display("FAIL rm_async_clear valid=%b flit=%h busy=%b exp 0/0/0", bus.flit_valid_o, bus.flit_o, bus.busy_o); end
    total++; if (cnt(0) != 4 || bus.req_ready_o !== 1'b1 || bus.pld_ready_o !== 1'b0) begin bad++; $display("FAIL rm_restore cnt=%0d req_ready=%b pld_ready=%b exp 4/1/0", cnt(0), bus.req_ready_o, bus.pld_ready_o); end
    @(negedge clk);
    rst = 1'b0;
    words = 0;
    bus.pld_data_i = pld_q[0];
    send_req(2'd1, 2'd1, 1'b1, 4'd2);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    total++; if (bus.flit_valid_o !== 1'b1 || bus.flit_o !== 18'h05580) begin bad++; $display("FAIL rm_new_head valid=%b flit=%h exp 1/05580", bus.flit_valid_o, bus.flit_o); end
    bus.pld_valid_i = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    xpos = 2'd1;
    ypos = 2'd1;
    for (int i = 0; i < 8; i++) pld_q[i] = 16'h0;
    test_reset();
    test_packet();
    test_len01();
    test_credit_stall();
    test_payload_gap();
    test_credit_edges();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
